fifo_write_arbiter: RTL and testbench

//  Shares the single write port of one fifo instance among NUM_REQ producers (e.g. decode

---
 rtl/fifo_write_arbiter_pkg.sv | 16 +
 rtl/fifo_write_arbiter_if.sv | 28 ++
 rtl/fifo_write_arbiter_rr_priority_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_write_arbiter_pkg;

    typedef logic [31:0] word32_t;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Circular increment of a requester index within 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and fifo-side bus of the write arbiter.
// The slave modport is the arbiter's view, the master modport is the
// view of whatever drives producers and models the fifo.
interface fifo_write_arbiter_if
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_lock;
    word32_t [NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        fifo_full;
    logic                        fifo_write;
    word32_t                     fifo_write_data;
    logic                        fifo_reset;
    logic [$clog2(NUM_REQ)-1:0]  grant_id;

    modport slave (
        input  req_valid, req_lock, req_data, fifo_full,
        output req_ready, fifo_write, fifo_write_data, fifo_reset, grant_id
    );

    modport master (
        output req_valid, req_lock, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_write_data, fifo_reset, grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational circular priority picker: returns the first set bit of
// valid_i at or after start_i, wrapping from N-1 back to 0.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan N positions starting at start_i; the first valid one wins.
    always_comb begin
        int cand;
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(start_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found_o && valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// A granted producer holding req_lock keeps the port for up to MAX_BURST
// consecutive transfers. Grant, ready and write are all same-cycle.
// The arbiter also drives the fifo reset from reset_i or flush_i.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    fifo_write_arbiter_if.slave  bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2) begin : g_num_req_check
        $error("fifo_write_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_max_burst_check
        $error("fifo_write_arbiter: MAX_BURST must be >= 1");
    end

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_nxt;

    logic              block;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;

    assign block     = reset_i | flush_i;
    assign burst_nxt = burst_cnt + CNT_W'(1);

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_picker (
        .valid_i (bus.req_valid),
        .start_i (rr_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Decide who transfers this cycle and drive the fifo write port from it.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!block && !bus.fifo_full) begin
            if (state == ARB_RR) begin
                grant_vld = pick_found;
                grant_idx = pick_idx;
            end else if (bus.req_valid[owner]) begin
                grant_vld = 1'b1;
                grant_idx = owner;
            end
        end

        bus.req_ready       = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
        bus.fifo_write      = grant_vld;
        bus.fifo_write_data = grant_vld ? bus.req_data[grant_idx] : '0;
        bus.grant_id        = grant_vld ? grant_idx : '0;
        bus.fifo_reset      = block;
    end

    // Arbitration FSM: round-robin pointer advance and locked-burst tracking.
    always_ff @(posedge clk_i) begin
        if (block) begin
            state     <= ARB_RR;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ARB_RR: begin
                    if (grant_vld) begin
                        if (bus.req_lock[grant_idx] && (MAX_BURST > 1)) begin
                            owner     <= grant_idx;
                            burst_cnt <= CNT_W'(1);
                            state     <= ARB_BURST;
                        end else begin
                            rr_ptr <= ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
                        end
                    end
                end
                ARB_BURST: begin
                    if (!bus.req_valid[owner]) begin
                        state     <= ARB_RR;
                        rr_ptr    <= ID_W'(wrap_inc(int'(owner), NUM_REQ));
                        burst_cnt <= '0;
                    end else if (!bus.fifo_full) begin
                        if (!bus.req_lock[owner] || burst_nxt == CNT_W'(MAX_BURST)) begin
                            state     <= ARB_RR;
                            rr_ptr    <= ID_W'(wrap_inc(int'(owner), NUM_REQ));
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_nxt;
                        end
                    end
                end
                default: begin
                    state <= ARB_RR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_fifo_write_arbiter;
    import fifo_write_arbiter_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [1:0] gid;
        word32_t    data;
        logic [3:0] rdy;
        logic       frst;
    } exp_t;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] lock;
        logic       full;
        logic       flush;
        logic       rst;
    } stim_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic tb_full = 1'b0;
    logic use_fifo = 1'b0;
    logic fifo_rd = 1'b0;
    int   fifo_cnt = 0;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    fifo_write_arbiter_if #(.NUM_REQ(4)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ   (4),
        .MAX_BURST (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_full = use_fifo ? (fifo_cnt >= 3) : tb_full;

    // Behavioural fifo holding three entries, used by the capacity test.
    always @(posedge clk) begin
        if (bus.fifo_reset) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + (bus.fifo_write ? 1 : 0) - ((fifo_rd && fifo_cnt > 0) ? 1 : 0);
    end

    function automatic word32_t data_of(input int g);
        return word32_t'(32'h1111_1111 * (g + 1));
    endfunction

    function automatic exp_t e(input int g, input logic frst);
        exp_t x;
        x = '0;
        x.frst = frst;
        if (g >= 0) begin
            x.wr   = 1'b1;
            x.gid  = 2'(g);
            x.data = data_of(g);
            x.rdy  = 4'(1 << g);
        end
        return x;
    endfunction

    function automatic stim_t s(input logic [3:0] v, input logic [3:0] l,
                                input logic f, input logic fl, input logic r);
        stim_t x;
        x.valid = v; x.lock = l; x.full = f; x.flush = fl; x.rst = r;
        return x;
    endfunction

    function automatic exp_t observe();
        exp_t x;
        x.wr   = bus.fifo_write;
        x.gid  = bus.grant_id;
        x.data = bus.fifo_write_data;
        x.rdy  = bus.req_ready;
        x.frst = bus.fifo_reset;
        return x;
    endfunction

    task automatic drive(input stim_t st);
        @(posedge clk);
        #1;
        bus.req_valid = st.valid;
        bus.req_lock  = st.lock;
        tb_full       = st.full;
        flush         = st.flush;
        rst           = st.rst;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'hF, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b1, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b1, 1'b0)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_round_robin();
        stim_t st[$];
        exp_t got, want;
        int order[5] = '{0, 1, 2, 3, 0};
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        for (int k = 0; k < 5; k++) begin
            st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(order[k], 1'b0));
        end
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL round_robin cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_full_stall();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(s(4'hF, 4'h0, 1'b1, 1'b0, 1'b0)); exp_q.push_back(e(-1, 1'b0));
        end
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(2, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL full_stall cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_locked_burst();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'h2, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(s(4'h7, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        end
        st.push_back(s(4'h7, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(2, 1'b0));
        st.push_back(s(4'h5, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        st.push_back(s(4'h5, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(2, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL locked_burst cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_burst_stall();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'h2, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h6, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(s(4'h6, 4'h2, 1'b1, 1'b0, 1'b0)); exp_q.push_back(e(-1, 1'b0));
        end
        st.push_back(s(4'h6, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h6, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h6, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(2, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL burst_stall cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'h2, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h7, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h7, 4'h2, 1'b0, 1'b1, 1'b0)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'h7, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL flush cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_lock_release();
        stim_t st[$];
        exp_t got, want;
        st.push_back(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1)); exp_q.push_back(e(-1, 1'b1));
        st.push_back(s(4'h3, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        st.push_back(s(4'h3, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h3, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h3, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        st.push_back(s(4'h2, 4'h2, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(1, 1'b0));
        st.push_back(s(4'h1, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(-1, 1'b0));
        st.push_back(s(4'h3, 4'h0, 1'b0, 1'b0, 1'b0)); exp_q.push_back(e(0, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL lock_release cyc%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_fifo_capacity();
        int writes;
        int last_gid;
        use_fifo = 1'b1;
        drive(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b1));
        writes = 0;
        for (int k = 0; k < 6; k++) begin
            drive(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0));
            @(negedge clk);
            if (bus.fifo_write) writes++;
        end
        checks++;
        if (writes !== 3) begin
            errors++;
            $display("[TB] FAIL fifo_fill writes=%0d exp=3", writes);
        end
        writes = 0;
        last_gid = -1;
        drive(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0));
        fifo_rd = 1'b1;
        @(negedge clk);
        if (bus.fifo_write) writes++;
        for (int k = 0; k < 5; k++) begin
            drive(s(4'hF, 4'h0, 1'b0, 1'b0, 1'b0));
            fifo_rd = 1'b0;
            @(negedge clk);
            if (bus.fifo_write) begin
                writes++;
                last_gid = int'(bus.grant_id);
            end
        end
        checks++;
        if (writes !== 1) begin
            errors++;
            $display("[TB] FAIL fifo_refill writes=%0d exp=1", writes);
        end
        checks++;
        if (last_gid !== 3) begin
            errors++;
            $display("[TB] FAIL fifo_refill_gid got=%0d exp=3", last_gid);
        end
        use_fifo = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        for (int i = 0; i < 4; i++) bus.req_data[i] = data_of(i);
        test_reset();
        test_round_robin();
        test_full_stall();
        test_locked_burst();
        test_burst_stall();
        test_flush();
        test_lock_release();
        test_fifo_capacity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
